// File: rtl/ray_frame_buffer.sv
// ray_frame_buffer
//   Double-buffered low-res frame store. Ray pixels are written at random
//   addresses into the back buffer; the front buffer is read in display
//   raster order with 4x upscaling. Buffers swap only on the frame-boundary
//   strobe (hcount==0, vcount==FULL_SCREEN_HEIGHT) after a last-pixel mark.
// Ports:
//   pixel_clk_in, rst_in        clock, async active-high reset
//   ray_valid_in/address/pixel  back-buffer write port
//   ray_last_pixel_in           end of frame packet, arms the swap
//   fb_ready_to_switch_out      2'b11 back writable, 2'b00 swap pending
//   hcount_in, vcount_in        display raster position (incl. blanking)
//   pixel_out                   upscaled front pixel, 2-cycle latency
//   new_frame_out               one-cycle pulse after the swap edge
//   front_sel_out               buffer currently displayed
module ray_frame_buffer #(
  parameter int PIXEL_WIDTH        = 16,
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 180,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   ray_valid_in,
  input  logic [15:0]            ray_address_in,
  input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
  input  logic                   ray_last_pixel_in,
  output logic [1:0]             fb_ready_to_switch_out,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   new_frame_out,
  output logic                   front_sel_out
);

  localparam int          DEPTH   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);
  localparam logic [10:0] H_ACT   = 11'(FULL_SCREEN_WIDTH);
  localparam logic [9:0]  V_ACT   = 10'(FULL_SCREEN_HEIGHT);

  typedef enum logic {WRITING, SWAP_PENDING} state_t;

  state_t                 state_q, state_d;
  logic                   front_sel_q, front_sel_d;
  logic [1:0]             ready_q, ready_d;
  logic                   new_frame_q, new_frame_d;
  logic                   wr_en;
  logic                   strobe;

  logic [15:0]            rd_addr_q, rd_addr_d;
  logic                   active_q, active_d;
  logic                   rd_sel_q;
  logic [PIXEL_WIDTH-1:0] pixel_q;
  logic [15:0]            v_row;

  logic [PIXEL_WIDTH-1:0] mem0 [0:DEPTH-1];
  logic [PIXEL_WIDTH-1:0] mem1 [0:DEPTH-1];

  assign strobe = (hcount_in == '0) && (vcount_in == V_ACT);

  // Read address: (h>>2) + (v>>2)*320, the multiply as (v<<8)+(v<<6).
  always_comb begin
    v_row     = {8'b0, vcount_in[9:2]};
    rd_addr_d = {7'b0, hcount_in[10:2]} + (v_row << 8) + (v_row << 6);
    active_d  = (hcount_in < H_ACT) && (vcount_in < V_ACT);
  end

  // State and output registers
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= WRITING;
      front_sel_q <= 1'b0;
      ready_q     <= 2'b11;
      new_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      ready_q     <= ready_d;
      new_frame_q <= new_frame_d;
    end
  end

  // Next-state logic; a strobe while WRITING is ignored, so last+strobe in
  // one cycle simply waits for the following strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WRITING:      if (ray_last_pixel_in) state_d = SWAP_PENDING;
      SWAP_PENDING: if (strobe)            state_d = WRITING;
      default:      state_d = WRITING;
    endcase
  end

  // Output logic
  always_comb begin
    front_sel_d = front_sel_q;
    new_frame_d = 1'b0;
    ready_d     = (state_d == WRITING) ? 2'b11 : 2'b00;
    wr_en       = (state_q == WRITING) && ray_valid_in && (ray_address_in < DEPTH16);
    if ((state_q == SWAP_PENDING) && strobe) begin
      front_sel_d = ~front_sel_q;
      new_frame_d = 1'b1;
    end
  end

  // Back-buffer write port (back = not front)
  always_ff @(posedge pixel_clk_in) begin
    if (wr_en) begin
      if (front_sel_q) mem0[ray_address_in] <= ray_pixel_in;
      else             mem1[ray_address_in] <= ray_pixel_in;
    end
  end

  // Read pipeline; buffer select travels with the address so a swap can
  // never split one read across buffers.
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_addr_q <= '0;
      active_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      pixel_q   <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      active_q  <= active_d;
      rd_sel_q  <= front_sel_q;
      if (active_q) pixel_q <= rd_sel_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
      else          pixel_q <= '0;
    end
  end

  assign fb_ready_to_switch_out = ready_q;
  assign new_frame_out          = new_frame_q;
  assign front_sel_out          = front_sel_q;
  assign pixel_out              = pixel_q;

endmodule

// File: tb/tb_ray_frame_buffer.sv
module tb_ray_frame_buffer;

  localparam int DEPTH = 320 * 180;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] pix = '0;
  logic        last = 1'b0;
  logic [1:0]  ready;
  logic [10:0] h = 11'd1300;
  logic [9:0]  v = 10'd100;
  logic [15:0] pout;
  logic        nf;
  logic        fsel;

  ray_frame_buffer #(.PIXEL_WIDTH(16), .SCREEN_WIDTH(320), .SCREEN_HEIGHT(180),
                     .FULL_SCREEN_WIDTH(1280), .FULL_SCREEN_HEIGHT(720)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .ray_valid_in(valid), .ray_address_in(addr),
    .ray_pixel_in(pix), .ray_last_pixel_in(last), .fb_ready_to_switch_out(ready),
    .hcount_in(h), .vcount_in(v), .pixel_out(pout), .new_frame_out(nf),
    .front_sel_out(fsel));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: two frame images plus "known" flags, the displayed
  // index, a pending-swap flag and a two-deep expected-pixel delay line.
  logic [15:0] mm [2][DEPTH];
  bit          kn [2][DEPTH];
  bit          m_front, m_pending, m_nf;
  logic [15:0] p1_val, exp_pix;
  bit          p1_kn, exp_kn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_front = 0; m_pending = 0; m_nf = 0;
    p1_val = '0; p1_kn = 1; exp_pix = '0; exp_kn = 1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) kn[b][a] = 0;
  endtask

  task automatic model_edge();
    int ra;
    if (rst) begin reset_model(); return; end
    exp_pix = p1_val; exp_kn = p1_kn;
    if (h < 1280 && v < 720) begin
      ra = int'(h) / 4 + (int'(v) / 4) * 320;
      p1_val = mm[m_front][ra]; p1_kn = kn[m_front][ra];
    end else begin
      p1_val = '0; p1_kn = 1;
    end
    m_nf = 0;
    if (m_pending) begin
      if (h == 0 && v == 720) begin m_front = !m_front; m_pending = 0; m_nf = 1; end
    end else begin
      if (valid && int'(addr) < DEPTH) begin
        mm[!m_front][addr] = pix; kn[!m_front][addr] = 1;
      end
      if (last) m_pending = 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("ready", 32'(ready), m_pending ? 32'd0 : 32'd3);
    chk("front_sel", 32'(fsel), 32'(m_front));
    chk("new_frame", 32'(nf), 32'(m_nf));
    if (exp_kn) chk("pixel", 32'(pout), 32'(exp_pix));
  endtask

  task automatic idle();
    valid = 0; last = 0; h = 11'd1300; v = 10'd100;
  endtask

  logic [15:0] val_a1, val0, val2;

  initial begin
    reset_model();
    // Reset state
    step(); step();
    chk("rst_ready", 32'(ready), 32'd3);
    chk("rst_front", 32'(fsel), 32'd0);
    chk("rst_pixel", 32'(pout), 32'd0);
    chk("rst_nf", 32'(nf), 32'd0);
    rst = 0;

    // Writes without last; strobes must not swap
    valid = 1; addr = 16'd0; pix = 16'h1234; step();
    addr = 16'd57599; pix = 16'hABCD; step();
    valid = 0; h = 11'd0; v = 10'd720;
    for (int i = 0; i < 3; i++) step();
    chk("no_swap_front", 32'(fsel), 32'd0);
    chk("no_swap_ready", 32'(ready), 32'd3);

    // Full frame into buffer 1, last on 57599
    idle();
    valid = 1;
    for (int a = 0; a < DEPTH; a++) begin
      addr = 16'(a); pix = 16'($urandom); last = (a == DEPTH - 1);
      step();
    end
    val_a1 = mm[1][1];
    chk("pend_ready", 32'(ready), 32'd0);
    idle(); step();
    h = 11'd0; v = 10'd720; step();
    chk("swap_nf", 32'(nf), 32'd1);
    chk("swap_front", 32'(fsel), 32'd1);
    chk("swap_ready", 32'(ready), 32'd3);
    idle(); step();
    chk("nf_pulse_end", 32'(nf), 32'd0);

    // Upscaled raster block maps to low-res address 1
    for (int vv = 0; vv < 4; vv++)
      for (int hh = 4; hh < 8; hh++) begin
        h = 11'(hh); v = 10'(vv); step();
      end
    h = 11'd5; v = 10'd2; step(); step();
    chk("addr1_pix", 32'(pout), 32'(val_a1));
    h = 11'd1280; v = 10'd0; step(); step();
    chk("h_blank", 32'(pout), 32'd0);
    h = 11'd0; v = 10'd720; step(); step();
    chk("v_blank", 32'(pout), 32'd0);

    // Random raster reads with random back-buffer writes
    for (int i = 0; i < 200; i++) begin
      h = 11'($urandom_range(1649)); v = 10'($urandom_range(749));
      if (h == 0 && v == 720) v = 10'd0;
      valid = 1'($urandom); addr = 16'($urandom_range(DEPTH - 1)); pix = 16'($urandom);
      if (addr == 0) addr = 16'd3;
      step();
    end

    // Last pixel together with strobe: stored, no swap yet
    idle();
    valid = 1; last = 1; addr = 16'd0; pix = 16'($urandom); val0 = pix;
    h = 11'd0; v = 10'd720; step();
    chk("same_cyc_front", 32'(fsel), 32'd1);
    chk("same_cyc_ready", 32'(ready), 32'd0);
    // Writes ignored while pending
    last = 0; addr = 16'd0; pix = 16'h5555; h = 11'd1300; v = 10'd100; step();
    idle(); h = 11'd0; v = 10'd720; step();
    chk("swap2_front", 32'(fsel), 32'd0);
    idle(); h = 11'd0; v = 10'd0; step(); step();
    chk("pend_write_ignored", 32'(pout), 32'(val0));

    // Out-of-range address dropped, then last with valid low
    idle(); valid = 1; addr = 16'd60000; pix = 16'hDEAD; step();
    valid = 0; last = 1; step();
    last = 0; step();
    chk("last_novalid_ready", 32'(ready), 32'd0);
    h = 11'd0; v = 10'd720; step();
    chk("swap3_front", 32'(fsel), 32'd1);
    idle(); step();

    // Enter pending, then asynchronous reset between edges
    valid = 1; last = 1; addr = 16'd7; pix = 16'h0F0F; step();
    idle(); step();
    chk("pre_rst_ready", 32'(ready), 32'd0);
    #2 rst = 1; #1;
    chk("arst_ready", 32'(ready), 32'd3);
    chk("arst_front", 32'(fsel), 32'd0);
    chk("arst_nf", 32'(nf), 32'd0);
    chk("arst_pixel", 32'(pout), 32'd0);
    step();
    rst = 0;

    // Next frame lands in buffer 1
    valid = 1; last = 1; addr = 16'd2; pix = 16'($urandom); val2 = pix; step();
    idle(); h = 11'd0; v = 10'd720; step();
    chk("post_rst_front", 32'(fsel), 32'd1);
    idle(); h = 11'd9; v = 10'd3; step(); step();
    chk("post_rst_pix", 32'(pout), 32'(val2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
